alu_pipe: RTL and testbench

//  Parametrised, handshaked successor of the single-cycle datapath ALU. Adds a registered output

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_mul_seq.sv | 51 +++++
 rtl/alu_pipe.sv | 146 ++++++++++++++
 tb/tb_alu_pipe.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and the multiplier FSM states for alu_pipe.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_PADDSB = 4'b0001;
  localparam logic [3:0] OP_SUB    = 4'b0010;
  localparam logic [3:0] OP_AND    = 4'b0011;
  localparam logic [3:0] OP_NOR    = 4'b0100;
  localparam logic [3:0] OP_SLL    = 4'b0101;
  localparam logic [3:0] OP_SRL    = 4'b0110;
  localparam logic [3:0] OP_SRA    = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LHB    = 4'b1010;
  localparam logic [3:0] OP_LLB    = 4'b1011;
  localparam logic [3:0] OP_MUL    = 4'b1100;
  localparam logic [3:0] OP_JAL    = 4'b1101;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // Signed 8-bit add clamped to the int8 range; one PADDSB lane.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s;
    s = a + b;
    if ((a[7] == b[7]) && (s[7] != a[7]))
      return a[7] ? 8'h80 : 8'h7F;
    return s;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle over WIDTH cycles.
module alu_mul_seq
#(
  parameter int WIDTH = 16
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   count;

  // done marks the cycle in which the last partial product is folded in
  assign done = busy && (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      count   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      count   <= CNT_W'(WIDTH - 1);
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      product <= '0;
    end else if (busy) begin
      if (mplier[0])
        product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (count == '0)
        busy <= 1'b0;
      else
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with a registered result/flag stage, optional saturation and a sequential MUL.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 1,
  parameter int MUL_EN   = 1
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_src0,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  mul_state_t state, state_nxt;

  logic out_free, accept, is_mul, mul_start, load_alu, load_mul;
  logic mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   alu_result, sum, diff, mul_result;
  logic [2:0]         alu_flags, mul_flags;
  logic               ov, upd_nvz, upd_z;

  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (state == MUL_IDLE) && !mul_busy && out_free;
  assign accept    = in_valid && in_ready;
  assign is_mul    = (MUL_EN != 0) && (in_op == OP_MUL);
  assign mul_start = accept && is_mul;
  assign load_alu  = accept && !is_mul;
  assign load_mul  = (state == MUL_DONE) && out_free;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (in_src0),
    .b       (in_src1),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= MUL_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MUL_IDLE: if (mul_start) state_nxt = MUL_BUSY;
      MUL_BUSY: if (mul_done)  state_nxt = MUL_DONE;
      MUL_DONE: if (out_free)  state_nxt = MUL_IDLE;
      default:                 state_nxt = MUL_IDLE;
    endcase
  end

  always_comb begin
    sum        = in_src0 + in_src1;
    diff       = in_src0 - in_src1;
    ov         = 1'b0;
    upd_nvz    = 1'b0;
    upd_z      = 1'b0;
    alu_result = '0;
    alu_flags  = flags;
    case (in_op)
      OP_ADD: begin
        ov         = (in_src0[WIDTH-1] == in_src1[WIDTH-1]) && (sum[WIDTH-1] != in_src0[WIDTH-1]);
        alu_result = ((SATURATE != 0) && ov) ? (in_src0[WIDTH-1] ? SMIN : SMAX) : sum;
        upd_nvz    = 1'b1;
      end
      OP_SUB: begin
        ov         = (in_src0[WIDTH-1] != in_src1[WIDTH-1]) && (diff[WIDTH-1] != in_src0[WIDTH-1]);
        alu_result = ((SATURATE != 0) && ov) ? (in_src0[WIDTH-1] ? SMIN : SMAX) : diff;
        upd_nvz    = 1'b1;
      end
      OP_PADDSB: begin
        for (int i = 0; i < WIDTH/8; i++)
          alu_result[8*i +: 8] = sat_add8(in_src0[8*i +: 8], in_src1[8*i +: 8]);
      end
      OP_AND: begin alu_result = in_src0 & in_src1;    upd_z = 1'b1; end
      OP_NOR: begin alu_result = ~(in_src0 | in_src1); upd_z = 1'b1; end
      OP_SLL: begin alu_result = in_src0 << in_imm[SHW-1:0]; upd_z = 1'b1; end
      OP_SRL: begin alu_result = in_src0 >> in_imm[SHW-1:0]; upd_z = 1'b1; end
      OP_SRA: begin
        alu_result = WIDTH'($signed(in_src0) >>> in_imm[SHW-1:0]);
        upd_z      = 1'b1;
      end
      OP_LW, OP_SW: alu_result = in_src0 + in_imm;
      OP_LHB:       alu_result = {in_imm[7:0], in_src0[WIDTH-9:0]};
      OP_LLB:       alu_result = in_imm;
      OP_JAL:       alu_result = in_src1;
      default:      alu_result = '0;
    endcase
    if (upd_nvz) begin
      alu_flags[FLAG_N] = alu_result[WIDTH-1];
      alu_flags[FLAG_V] = ov;
      alu_flags[FLAG_Z] = (alu_result == '0);
    end else if (upd_z) begin
      alu_flags[FLAG_Z] = (alu_result == '0);
    end
  end

  always_comb begin
    mul_result        = mul_product[WIDTH-1:0];
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_result[WIDTH-1];
    mul_flags[FLAG_V] = |mul_product[2*WIDTH-1:WIDTH];
    mul_flags[FLAG_Z] = (mul_result == '0);
  end

  // A new load wins over a drain in the same cycle, so back-to-back ops leave no bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      flags      <= '0;
    end else if (load_alu) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      flags      <= alu_flags;
    end else if (load_mul) begin
      out_valid  <= 1'b1;
      out_result <= mul_result;
      flags      <= mul_flags;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed literal checks plus randomized ops against a queue-based reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  flg;
    bit          is_mul;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [15:0] in_src0 = '0;
  logic [15:0] in_src1 = '0;
  logic [15:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic [2:0]  flags;

  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_ready = 1'b0;
  exp_t q[$];
  logic [2:0] mflags = '0;
  bit   mul_inflight = 1'b0;
  bit   after_reset = 1'b0;

  alu_pipe #(.WIDTH(16), .SATURATE(1), .MUL_EN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src0    (in_src0),
    .in_src1    (in_src1),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .flags      (flags)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on integers, flags {N,V,Z}
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] imm, input logic [2:0] f);
    exp_t e;
    int sa, sb, s;
    longint p;
    logic [15:0] r;
    bit v;
    e.flg = f;
    e.is_mul = 0;
    sa = $signed(a);
    sb = $signed(b);
    r = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        s = (op == OP_ADD) ? sa + sb : sa - sb;
        v = (s > 32767) || (s < -32768);
        r = v ? ((s > 0) ? 16'h7FFF : 16'h8000) : 16'(s);
        e.flg = {r[15], v, (r == 16'h0)};
      end
      OP_PADDSB: begin
        for (int i = 0; i < 2; i++) begin
          int x;
          x = $signed(a[8*i +: 8]) + $signed(b[8*i +: 8]);
          if (x > 127) x = 127;
          if (x < -128) x = -128;
          r[8*i +: 8] = 8'(x);
        end
      end
      OP_AND: begin r = a & b;              e.flg[0] = (r == 16'h0); end
      OP_NOR: begin r = ~(a | b);           e.flg[0] = (r == 16'h0); end
      OP_SLL: begin r = a << imm[3:0];      e.flg[0] = (r == 16'h0); end
      OP_SRL: begin r = a >> imm[3:0];      e.flg[0] = (r == 16'h0); end
      OP_SRA: begin r = 16'(sa >>> imm[3:0]); e.flg[0] = (r == 16'h0); end
      OP_LW, OP_SW: r = a + imm;
      OP_LHB: r = {imm[7:0], a[7:0]};
      OP_LLB: r = imm;
      OP_JAL: r = b;
      OP_MUL: begin
        p = longint'(a) * longint'(b);
        r = p[15:0];
        e.flg = {r[15], (p[31:16] != 16'h0), (r == 16'h0)};
        e.is_mul = 1;
      end
      default: r = '0;
    endcase
    e.res = r;
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    bit in_fire, out_fire;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        mflags = '0;
        mul_inflight = 0;
        after_reset = 1;
      end else begin
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (after_reset) begin
          check_output("post_reset_out_valid", 32'(out_valid), 32'd0);
          check_output("post_reset_flags", 32'(flags), 32'd0);
          after_reset = 0;
        end
        if (out_valid && q.size() > 0 && q[0].is_mul)
          mul_inflight = 0;
        check_output("in_ready", 32'(in_ready), 32'(!mul_inflight && (!out_valid || out_ready)));
        if (out_valid) begin
          if (q.size() == 0) begin
            check_output("unexpected_result", 32'(out_result), 32'hDEAD_BEEF);
          end else begin
            check_output("result", 32'(out_result), 32'(q[0].res));
            check_output("flags", 32'(flags), 32'(q[0].flg));
          end
          if (out_fire && q.size() > 0) void'(q.pop_front());
        end
        if (in_fire) begin
          e = model(in_op, in_src0, in_src1, in_imm, mflags);
          mflags = e.flg;
          q.push_back(e);
          if (e.is_mul) mul_inflight = 1;
        end
      end
    end
  end

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Presents one op, waits (bounded) for acceptance, returns 1 time unit after the accept edge
  task automatic apply_stimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] imm);
    int waited = 0;
    in_op = op; in_src0 = a; in_src1 = b; in_imm = imm; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check_output("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] rnd_val();
    logic [15:0] specials [7] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0080, 16'h7F7F};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 6)];
    return 16'($urandom);
  endfunction

  initial begin : main
    int lat;
    int guard;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_out_result", 32'(out_result), 32'd0);
    check_output("reset_flags", 32'(flags), 32'd0);
    check_output("reset_in_ready", 32'(in_ready), 32'd1);

    apply_stimulus(OP_ADD, 16'h0003, 16'h0004, 16'h0);
    check_output("add_valid", 32'(out_valid), 32'd1);
    check_output("add_result", 32'(out_result), 32'h0007);
    check_output("add_flags", 32'(flags), 32'b000);

    apply_stimulus(OP_ADD, 16'h7FFF, 16'h0001, 16'h0);
    check_output("add_sat_result", 32'(out_result), 32'h7FFF);
    check_output("add_sat_flags", 32'(flags), 32'b010);
    apply_stimulus(OP_SUB, 16'h8000, 16'h0001, 16'h0);
    check_output("sub_sat_result", 32'(out_result), 32'h8000);
    check_output("sub_sat_flags", 32'(flags), 32'b110);

    apply_stimulus(OP_PADDSB, 16'h7F80, 16'h0180, 16'h0);
    check_output("paddsb_result", 32'(out_result), 32'h7F80);
    check_output("paddsb_flags", 32'(flags), 32'b110);

    // MUL latency with an ADD held waiting at the input
    apply_stimulus(OP_MUL, 16'h0100, 16'h0101, 16'h0);
    in_op = OP_ADD; in_src0 = 16'h0001; in_src1 = 16'h0001; in_valid = 1'b1;
    lat = -1;
    for (int k = 0; k <= 40 && lat < 0; k++) begin
      if (out_valid) lat = k;
      else begin
        check_output("mul_busy_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
      end
    end
    check_output("mul_latency", 32'(lat), 32'd17);
    check_output("mul_result", 32'(out_result), 32'h0100);
    check_output("mul_flags", 32'(flags), 32'b010);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_output("held_add_result", 32'(out_result), 32'h0002);
    check_output("held_add_flags", 32'(flags), 32'b000);

    // Output stall with more ops queued behind the first
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    apply_stimulus(OP_AND, 16'h00FF, 16'h0F0F, 16'h0);
    in_op = OP_LLB; in_src0 = 16'h0; in_src1 = 16'h0; in_imm = 16'h1234; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_output("stall_valid", 32'(out_valid), 32'd1);
      check_output("stall_result", 32'(out_result), 32'h000F);
      check_output("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    apply_stimulus(OP_LLB, 16'h0, 16'h0, 16'h1234);
    check_output("stall_second", 32'(out_result), 32'h1234);
    apply_stimulus(OP_JAL, 16'h0, 16'hBEEF, 16'h0);
    check_output("stall_third", 32'(out_result), 32'hBEEF);

    // Reset in the middle of a multiply
    apply_stimulus(OP_ADD, 16'h7FFF, 16'h0001, 16'h0);
    apply_stimulus(OP_MUL, 16'h0003, 16'h0005, 16'h0);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("mulrst_out_valid", 32'(out_valid), 32'd0);
    check_output("mulrst_flags", 32'(flags), 32'd0);
    check_output("mulrst_in_ready", 32'(in_ready), 32'd1);
    apply_stimulus(OP_ADD, 16'h0005, 16'h0006, 16'h0);
    check_output("mulrst_add_result", 32'(out_result), 32'h000B);
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
    check_output("mulrst_no_ghost", 32'(out_valid), 32'd0);

    // Randomized traffic with random downstream back-pressure
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      apply_stimulus(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), rnd_val());
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #3;
    out_ready = 1'b1;
    guard = 0;
    while ((q.size() != 0 || out_valid) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_output("drain_empty", 32'(q.size()), 32'd0);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
